// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port arbiter sharing one memory/IO bus with locked transfers and bounded lock length.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; the default is fixed priority to port 0.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;

    logic [1:0]            state;
    logic                  owner, lock_l, we_l;
    logic [CW-1:0]         lock_cnt, cnt_next;
    logic                  any, own_req, oth_req, locked, forced, tie_win, win, lock_in, we_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] wdata_in;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;
    assign tie_win = ~last;
    always_ff @(posedge clk or negedge reset)
        if (!reset) last <= 1'b1;
        else if (state != ACCESS && any) last <= win;
`else
    assign tie_win = 1'b0;
`endif

    always_comb begin
        any      = req0 | req1;
        own_req  = owner ? req1 : req0;
        oth_req  = owner ? req0 : req1;
        locked   = lock_l && own_req && lock_cnt < LMAX;
        forced   = lock_cnt == LMAX && oth_req;
        win      = locked ? owner : forced ? ~owner : (req0 && req1) ? tie_win : req1;
        lock_in  = win ? lock1 : lock0;
        we_in    = win ? we1 : we0;
        addr_in  = win ? addr1 : addr0;
        wdata_in = win ? wdata1 : wdata0;
        // a new owner's locked access is the first of its run
        cnt_next = !lock_in ? '0 : win != owner ? CW'(1) : lock_cnt == LMAX ? lock_cnt : lock_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lock_l    <= 1'b0;
            we_l      <= 1'b0;
            lock_cnt  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else if (state == ACCESS) begin
            state <= RESP;
            if (!we_l && !owner) rdata0 <= bus_rdata;
            if (!we_l && owner) rdata1 <= bus_rdata;
        end else if (any) begin
            state     <= ACCESS;
            owner     <= win;
            lock_l    <= lock_in;
            we_l      <= we_in;
            bus_addr  <= addr_in;
            bus_wdata <= wdata_in;
            lock_cnt  <= cnt_next;
        end else begin
            state <= IDLE;
        end
    end

    assign gnt0   = (state == ACCESS || state == RESP) && !owner;
    assign gnt1   = (state == ACCESS || state == RESP) && owner;
    assign ack0   = state == RESP && !owner;
    assign ack1   = state == RESP && owner;
    assign mem_cs = state == ACCESS;
    assign mem_we = mem_cs && we_l;
    assign mem_oe = mem_cs && !we_l;
endmodule
